// File: rtl/fab_counter_pkg.sv
// rtl/fab_counter_pkg.sv - shared constants and helpers for the fabric counter bank
package fab_counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // All-ones value of a width-bit counter; widths above 32 clamp to 32 ones.
    function automatic logic [31:0] max_count(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/fab_counter_bank_if.sv
// rtl/fab_counter_bank_if.sv - control and result bundle of the counter bank
interface fab_counter_bank_if #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int PRESCALE_W = 4
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       sat_mode;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_val;
    logic [PRESCALE_W-1:0]     prescale;
    logic                      tick;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       tc;

    modport master (
        output en, dir, sat_mode, load, load_val, prescale,
        input  tick, count, tc
    );

    modport slave (
        input  en, dir, sat_mode, load, load_val, prescale,
        output tick, count, tc
    );
endinterface

// File: rtl/fab_counter_chan.sv
// rtl/fab_counter_chan.sv - one counter channel: load, up/down step, wrap/saturate, tc pulse
module fab_counter_chan
    import fab_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));

    logic [WIDTH-1:0] count_next;
    logic             tc_next;

    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (step_en) begin
            if (dir == DIR_UP) begin
                if (count == MAX) begin
                    count_next = (sat_mode == MODE_SAT) ? MAX : '0;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    count_next = (sat_mode == MODE_SAT) ? '0 : MAX;
                    tc_next    = 1'b1;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
        end
    end
endmodule

// File: rtl/fab_counter_bank.sv
// rtl/fab_counter_bank.sv - multi-channel counter bank with shared programmable prescaler
module fab_counter_bank
    import fab_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int PRESCALE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    fab_counter_bank_if.slave  bus
);
    logic [PRESCALE_W-1:0]     pcnt;
    logic                      tick;
    logic [CHANNELS*WIDTH-1:0] count_w;
    logic [CHANNELS-1:0]       tc_w;

    // Compare with >= so lowering prescale below pcnt fires at once instead of wrapping.
    assign tick = (pcnt >= bus.prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        fab_counter_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .step_en  (bus.en[i] & tick),
            .dir      (bus.dir[i]),
            .sat_mode (bus.sat_mode[i]),
            .load     (bus.load[i]),
            .load_val (bus.load_val[i*WIDTH +: WIDTH]),
            .count    (count_w[i*WIDTH +: WIDTH]),
            .tc       (tc_w[i])
        );
    end

    assign bus.tick  = tick;
    assign bus.count = count_w;
    assign bus.tc    = tc_w;
endmodule

// File: tb/tb_fab_counter_bank.sv
// tb/tb_fab_counter_bank.sv - directed self-checking bench for fab_counter_bank
module tb_fab_counter_bank;
    localparam int WIDTH      = 8;
    localparam int CHANNELS   = 2;
    localparam int PRESCALE_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fab_counter_bank_if #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESCALE_W(PRESCALE_W)
    ) bus ();

    fab_counter_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return bus.count[ch*WIDTH +: WIDTH];
    endfunction

    initial begin
        reset        = 1'b1;
        bus.en       = '0;
        bus.dir      = '0;
        bus.sat_mode = '0;
        bus.load     = '0;
        bus.load_val = '0;
        bus.prescale = '0;
        cycle();
        cycle();
        check("reset_count", bus.count, 32'h0);
        check("reset_tc", bus.tc, 32'h0);
        check("reset_tick_p0", bus.tick, 32'h1);

        // 1: ch0 up-wrap, prescale 0
        reset      = 1'b0;
        bus.en     = 2'b01;
        bus.dir    = 2'b01;
        for (int k = 1; k <= 256; k++) begin
            cycle();
            check("t1_count0", cnt(0), k % 256);
            check("t1_tc0", bus.tc[0], (k == 256) ? 1 : 0);
        end
        bus.en = 2'b00;
        cycle();
        check("t1_tc0_drop", bus.tc[0], 32'h0);

        // 2: ch1 load 3, down saturate
        bus.load_val     = 16'h0300;
        bus.load         = 2'b10;
        bus.en           = 2'b10;
        bus.dir          = 2'b01;
        bus.sat_mode     = 2'b10;
        cycle();
        check("t2_load", cnt(1), 32'd3);
        check("t2_load_tc", bus.tc[1], 32'h0);
        bus.load = 2'b00;
        begin
            int exp_c[5] = '{2, 1, 0, 0, 0};
            int exp_t[5] = '{0, 0, 0, 1, 1};
            for (int k = 0; k < 5; k++) begin
                cycle();
                check("t2_count1", cnt(1), exp_c[k]);
                check("t2_tc1", bus.tc[1], exp_t[k]);
            end
        end
        bus.en = 2'b00;
        cycle();
        check("t2_tc1_drop", bus.tc[1], 32'h0);
        check("t2_count0_idle", cnt(0), 32'h0);

        // 3: prescale 3, then lowered to 1 while pcnt=2
        bus.prescale = 4'd3;
        bus.en       = 2'b01;
        bus.dir      = 2'b01;
        bus.sat_mode = 2'b00;
        #1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) cycle();
            check("t3_tick", bus.tick, ((k % 4) == 3) ? 1 : 0);
            check("t3_count0", cnt(0), k / 4);
        end
        bus.prescale = 4'd1;
        #1;
        check("t3_lower_tick", bus.tick, 32'h1);
        cycle();
        check("t3_lower_cnt", cnt(0), 32'd3);
        check("t3_lower_tick1", bus.tick, 32'h0);
        cycle();
        check("t3_lower_tick2", bus.tick, 32'h1);
        check("t3_lower_cnt2", cnt(0), 32'd3);
        cycle();
        check("t3_lower_cnt3", cnt(0), 32'd4);
        check("t3_lower_tick3", bus.tick, 32'h0);
        bus.prescale = 4'd0;
        bus.en       = 2'b00;
        cycle();

        // 4: load beats wrap at MAX
        bus.load_val = 16'h00FF;
        bus.load     = 2'b01;
        cycle();
        check("t4_preload", cnt(0), 32'hFF);
        bus.load_val = 16'h005A;
        bus.en       = 2'b01;
        bus.dir      = 2'b01;
        cycle();
        check("t4_load_win", cnt(0), 32'h5A);
        check("t4_tc", bus.tc[0], 32'h0);
        bus.load = 2'b00;
        bus.en   = 2'b00;

        // 5: simultaneous up-wrap and down-wrap, then ch1 disabled
        bus.load_val = 16'h00FF;
        bus.load     = 2'b11;
        cycle();
        bus.load     = 2'b00;
        bus.en       = 2'b11;
        bus.dir      = 2'b01;
        bus.sat_mode = 2'b00;
        cycle();
        check("t5_count0", cnt(0), 32'h00);
        check("t5_count1", cnt(1), 32'hFF);
        check("t5_tc", bus.tc, 32'h3);
        bus.en = 2'b01;
        cycle();
        check("t5_count0_b", cnt(0), 32'h01);
        check("t5_count1_hold", cnt(1), 32'hFF);
        check("t5_tc_b", bus.tc, 32'h0);
        bus.en = 2'b00;

        // 6: reset with load pending and prescale 5
        bus.en       = 2'b11;
        bus.dir      = 2'b11;
        bus.load     = 2'b11;
        bus.load_val = 16'h7777;
        bus.prescale = 4'd5;
        reset        = 1'b1;
        cycle();
        check("t6_count", bus.count, 32'h0);
        check("t6_tc", bus.tc, 32'h0);
        check("t6_tick", bus.tick, 32'h0);
        reset    = 1'b0;
        bus.load = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check("t6_wait_cnt", bus.count, 32'h0);
            check("t6_wait_tick", bus.tick, (k == 5) ? 1 : 0);
        end
        cycle();
        check("t6_resume", bus.count, 32'h0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
